// File: rtl/softmax_stream_seq_if.sv
// Stream interface for softmax_stream_seq: score input stream and probability output stream.
interface softmax_stream_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  // producer/consumer side (score source + weight sink)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // softmax block side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/softmax_stream_seq.sv
// Sequential softmax: loads N scores tracking the max, converts each to a base-2
// approximated exp term while summing, divides every term by the sum with a
// one-bit-per-cycle restoring divider, then streams the probabilities in order.
module softmax_stream_seq #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int F     = 12,
  parameter int SUM_W = F + 1 + $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  softmax_stream_seq_if.slave  s_io,
  output logic                 o_busy
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(F + 1);
  localparam int XW = W + 3;
  localparam int RW = SUM_W + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(F);
  localparam logic signed [W-1:0] MIN_X = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_DIV, S_OUT} state_t;

  state_t                r_state, w_next;
  logic [N-1:0][W-1:0]   r_buf;     // x_i, then e_i, then q_i in place
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;     // quotient bit step within one element
  logic signed [W-1:0]   r_max;
  logic [SUM_W-1:0]      r_sum;
  logic [SUM_W-1:0]      r_rem;     // remainder after subtract, before doubling
  logic [F-1:0]          r_quo;     // quotient bits collected so far

  logic                  w_cnt_last, w_in_fire, w_out_fire;
  logic [W-1:0]          w_cur;
  logic signed [XW-1:0]  w_dx, w_u, w_ush;
  logic [XW-1:0]         w_k;
  logic [F:0]            w_e;
  logic [RW-1:0]         w_rem_cur;
  logic                  w_qbit;
  logic [SUM_W-1:0]      w_rem_sub;
  logic [F:0]            w_q_next;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_in_fire  = (r_state == S_LOAD) && s_io.in_valid;
  assign w_out_fire = (r_state == S_OUT) && s_io.out_ready;
  assign w_cur      = r_buf[r_cnt];

  // exp term: d*log2(e) split into integer shift k and fraction f; 2^(-k)*(1+f)
  always_comb begin
    w_dx  = XW'($signed(w_cur)) - XW'(r_max);
    w_u   = w_dx + (w_dx >>> 1) - (w_dx >>> 4);
    w_ush = w_u >>> F;
    w_k   = XW'(-w_ush);
    w_e   = (w_k > XW'(F)) ? '0 : ({1'b1, w_u[F-1:0]} >> w_k);
  end

  // restoring divide step: first step of an element starts from e_i itself
  always_comb begin
    w_rem_cur = (r_bit == '0) ? RW'(w_cur[F:0]) : {r_rem, 1'b0};
    w_qbit    = (w_rem_cur >= {1'b0, r_sum});
    w_rem_sub = w_qbit ? SUM_W'(w_rem_cur - {1'b0, r_sum}) : w_rem_cur[SUM_W-1:0];
    w_q_next  = {r_quo, w_qbit};
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_LOAD;
    else          r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: if (w_in_fire && w_cnt_last)                    w_next = S_EXP;
      S_EXP:  if (w_cnt_last)                                 w_next = S_DIV;
      S_DIV:  if (w_cnt_last && (r_bit == BIT_LAST))          w_next = S_OUT;
      S_OUT:  if (w_out_fire && w_cnt_last)                   w_next = S_LOAD;
      default:                                                w_next = S_LOAD;
    endcase
  end

  // FSM outputs; out_* are combinational so reset drops out_valid immediately
  always_comb begin
    s_io.in_ready  = 1'b0;
    s_io.out_valid = 1'b0;
    s_io.out_last  = 1'b0;
    s_io.out_data  = '0;
    o_busy         = 1'b1;
    case (r_state)
      S_LOAD: begin
        s_io.in_ready = 1'b1;
        o_busy        = (r_cnt != '0);
      end
      S_OUT: begin
        s_io.out_valid = 1'b1;
        s_io.out_data  = w_cur;
        s_io.out_last  = w_cnt_last;
      end
      default: ;
    endcase
  end

  // datapath: buffer, index/bit counters, running max, exp sum, divider state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_bit <= '0;
      r_max <= MIN_X;
      r_sum <= '0;
      r_rem <= '0;
      r_quo <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (w_in_fire) begin
          r_buf[r_cnt] <= s_io.in_data;
          if ($signed(s_io.in_data) > r_max) r_max <= $signed(s_io.in_data);
          r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        S_EXP: begin
          r_buf[r_cnt] <= W'(w_e);
          r_sum        <= r_sum + SUM_W'(w_e);
          r_cnt        <= w_cnt_last ? '0 : r_cnt + 1'b1;
          r_bit        <= '0;
        end
        S_DIV: begin
          r_rem <= w_rem_sub;
          r_quo <= w_q_next[F-1:0];
          if (r_bit == BIT_LAST) begin
            r_buf[r_cnt] <= W'(w_q_next);
            r_bit        <= '0;
            r_cnt        <= w_cnt_last ? '0 : r_cnt + 1'b1;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        S_OUT: if (w_out_fire) begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_max <= MIN_X;
            r_sum <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_stream_seq.sv
// Bench for softmax_stream_seq: directed vectors, random vectors against an
// arithmetic reference model, backpressure, mid-run reset and latency.
module tb_softmax_stream_seq;
  localparam int N = 4;
  localparam int W = 16;
  localparam int F = 12;
  typedef logic [W-1:0] vec_t [N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  softmax_stream_seq_if #(.W(W)) bus ();

  softmax_stream_seq #(.N(N), .W(W), .F(F)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .s_io   (bus),
    .o_busy (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // reference: softmax from the exp/divide rules using plain integer math
  function automatic void model(input vec_t x, output vec_t p);
    int mx, d, u, k, f, sum;
    int e [N];
    mx = int'($signed(x[0]));
    for (int i = 1; i < N; i++) if (int'($signed(x[i])) > mx) mx = int'($signed(x[i]));
    sum = 0;
    for (int i = 0; i < N; i++) begin
      d = int'($signed(x[i])) - mx;
      u = d + (d >>> 1) - (d >>> 4);
      k = -(u >>> F);
      f = u & ((1 << F) - 1);
      e[i] = (k > F) ? 0 : (((1 << F) + f) >> k);
      sum += e[i];
    end
    for (int i = 0; i < N; i++) p[i] = W'((longint'(e[i]) << F) / longint'(sum));
  endfunction

  task automatic send(input vec_t v, input bit gaps);
    int g, t;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gaps) begin
        g = $urandom_range(0, 3);
        bus.in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      t = 0;
      while (!bus.in_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_wait", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  // mode 0: always ready; mode 1: toggling ready with a 10-cycle stall
  task automatic recv(input int mode, output vec_t got, output logic [N-1:0] lasts);
    int idx, c, w;
    logic rdy, held, hl;
    logic [W-1:0] hd;
    idx = 0; c = 0; w = 0; held = 1'b0; hd = '0; hl = 1'b0;
    for (int i = 0; i < N; i++) got[i] = 'x;
    lasts = 'x;
    @(negedge clk);
    while (!bus.out_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    while (idx < N && c < 3000) begin
      rdy = (mode == 0) ? 1'b1 : ((c >= 3 && c < 13) ? 1'b0 : c[0]);
      bus.out_ready = rdy;
      if (bus.out_valid) begin
        if (held) begin
          chk("hold_data", bus.out_data, hd);
          chk("hold_last", bus.out_last, hl);
        end
        if (rdy) begin
          got[idx] = bus.out_data;
          lasts[idx] = bus.out_last;
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = bus.out_data;
          hl = bus.out_last;
        end
      end
      @(negedge clk);
      c++;
    end
    bus.out_ready = 1'b0;
    chk("beats_received", idx, N);
    chk("no_extra_beat", bus.out_valid, 0);
  endtask

  task automatic check_vec(input string tag, input vec_t got, input logic [N-1:0] lasts,
                           input vec_t exp);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_data"}, got[i], exp[i]);
      chk({tag, "_last"}, lasts[i], (i == N - 1) ? 1 : 0);
    end
  endtask

  initial begin
    vec_t v, exp, mdl, got;
    logic [N-1:0] lasts;
    int n, s;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // test 1: equal inputs
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    exp = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    send(v, 1'b0);
    chk("t1_busy", busy, 1);
    recv(0, got, lasts);
    check_vec("t1", got, lasts, exp);
    chk("t1_idle_busy", busy, 0);

    // test 2: dominant element
    v = '{16'h7000, 16'h8000, 16'h8000, 16'h8000};
    exp = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    send(v, 1'b0);
    recv(0, got, lasts);
    check_vec("t2", got, lasts, exp);

    // test 3: one unit above the rest
    v = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    exp = '{16'h075D, 16'h02E0, 16'h02E0, 16'h02E0};
    send(v, 1'b0);
    recv(0, got, lasts);
    check_vec("t3", got, lasts, exp);

    // test 4: mixed signs, max at index 2
    v = '{16'hEC80, 16'hFE18, 16'h2771, 16'h15DB};
    model(v, mdl);
    send(v, 1'b0);
    recv(0, got, lasts);
    check_vec("t4", got, lasts, mdl);
    s = 0;
    for (int i = 0; i < N; i++) s += int'(got[i]);
    chk("t4_sum_le_one", (s <= 32'h1000) ? 1 : 0, 1);
    for (int i = 0; i < N; i++)
      if (i != 2) chk("t4_max_largest", (got[2] > got[i]) ? 1 : 0, 1);

    // test 5: input gaps plus output backpressure, same result as test 3
    v = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    exp = '{16'h075D, 16'h02E0, 16'h02E0, 16'h02E0};
    send(v, 1'b1);
    recv(1, got, lasts);
    check_vec("t5", got, lasts, exp);

    // random vectors against the reference model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        v[i] = (r < 4) ? W'($urandom_range(0, 16'h3FFF) - 16'h2000) : W'($urandom);
      model(v, mdl);
      send(v, r[0]);
      recv(r % 2, got, lasts);
      check_vec("rand", got, lasts, mdl);
    end

    // test 6: reset during DIV, then a fresh vector with latency check
    v = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    send(v, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    chk("t6_busy_div", busy, 1);
    chk("t6_valid_div", bus.out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", bus.in_ready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_out_valid", bus.out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    exp = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    send(v, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t6_latency", n, N + N * (F + 1));
    recv(0, got, lasts);
    check_vec("t6", got, lasts, exp);

    // reset while presenting output: out_valid falls without a clock edge
    send(v, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t7_valid_before", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", bus.out_valid, 0);
    chk("t7_async_data", bus.out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    v = '{16'h7000, 16'h8000, 16'h8000, 16'h8000};
    exp = '{16'h1000, 16'h0000, 16'h0000, 16'h0000};
    send(v, 1'b0);
    recv(0, got, lasts);
    check_vec("t7", got, lasts, exp);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
